// File: rtl/tinyalu_rr_arbiter.sv
// Round-robin front end that shares one TinyALU between requesters.
// Local ops answer in one cycle; a watchdog covers a missing done.
module tinyalu_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*8-1:0]   req_a,
  input  logic [NUM_REQ*8-1:0]   req_b,
  input  logic [NUM_REQ*3-1:0]   req_op,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [15:0]            rsp_result,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  output logic [2:0]             alu_op,
  output logic                   alu_start,
  input  logic                   alu_done,
  input  logic [15:0]            alu_result
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;
  logic [IW-1:0] sel;
  logic [IW-1:0] j;
  logic          found;
  logic          grant;
  logic [CW-1:0] cnt;
  logic [2:0]    sel_op;
  logic          sel_alu;
  logic          sel_nop;
  logic          wait_end;

  logic [7:0] a_arr  [NUM_REQ];
  logic [7:0] b_arr  [NUM_REQ];
  logic [2:0] op_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g]  = req_a[8*g +: 8];
    assign b_arr[g]  = req_b[8*g +: 8];
    assign op_arr[g] = req_op[3*g +: 3];
  end

  // Search starts just past the last winner and wraps.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    j     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = IW'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[j]) begin
        found = 1'b1;
        sel   = j;
      end
    end
  end

  assign grant   = reset_n && (state == IDLE) && found;
  assign gnt     = grant ? (NUM_REQ'(1) << sel) : '0;
  assign busy    = (state != IDLE);
  assign sel_op  = op_arr[sel];
  assign sel_alu = (sel_op != 3'd0) && (sel_op <= 3'd4);
  assign sel_nop = (sel_op == 3'd0);

  assign wait_end = alu_done || (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= IW'(NUM_REQ - 1);
      idx        <= '0;
      cnt        <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_start  <= 1'b0;
    end else begin
      rsp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (grant) begin
            ptr <= sel;
            idx <= sel;
            unique case (1'b1)
              sel_alu: begin
                state     <= ISSUE;
                alu_a     <= a_arr[sel];
                alu_b     <= b_arr[sel];
                alu_op    <= sel_op;
                alu_start <= 1'b1;
              end
              sel_nop: begin
                state      <= RESP;
                rsp_valid  <= gnt;
                rsp_result <= '0;
                rsp_err    <= 1'b0;
              end
              default: begin
                state      <= RESP;
                rsp_valid  <= gnt;
                rsp_result <= '0;
                rsp_err    <= 1'b1;
              end
            endcase
          end
        end
        ISSUE: begin
          state     <= WAIT;
          alu_start <= (alu_op == 3'd4);
          cnt       <= CW'(1);
        end
        WAIT: begin
          if (wait_end) begin
            state      <= RESP;
            rsp_valid  <= NUM_REQ'(1) << idx;
            rsp_result <= alu_done ? alu_result : '0;
            rsp_err    <= !alu_done;
            alu_start  <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          state      <= IDLE;
          rsp_result <= '0;
          rsp_err    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tinyalu_rr_arbiter.sv
// Bench for tinyalu_rr_arbiter: stub ALU plus a
// cycle-level grant/response reference model.
module tb_tinyalu_rr_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [N*8-1:0] req_a;
  logic [N*8-1:0] req_b;
  logic [N*3-1:0] req_op;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rsp_valid;
  logic [15:0]    rsp_result;
  logic           rsp_err;
  logic           busy;
  logic [7:0]     alu_a;
  logic [7:0]     alu_b;
  logic [2:0]     alu_op;
  logic           alu_start;
  logic           alu_done;
  logic [15:0]    alu_result;

  int errors = 0;
  int checks = 0;

  tinyalu_rr_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .busy(busy), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_result(
    input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd1: return 16'(a) + 16'(b);
      3'd2: return {8'h00, a & b};
      3'd3: return {8'h00, a ^ b};
      3'd4: return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  function automatic int lat(input logic [2:0] op);
    if (op >= 3'd1 && op <= 3'd3) return 3;
    if (op == 3'd4) return 5;
    return 1;
  endfunction

  // Stub ALU: 1-cycle for add/and/xor, 3-cycle for mult.
  bit         no_done = 1'b0;
  int         rem = 0;
  logic [2:0] s_op;
  logic [7:0] s_a, s_b;

  always @(posedge clk) begin
    if (!reset_n || no_done) begin
      alu_done   <= 1'b0;
      alu_result <= 16'h0;
      rem        <= 0;
    end else begin
      alu_done <= 1'b0;
      if (rem > 0) begin
        if (rem == 1) begin
          alu_done   <= 1'b1;
          alu_result <= ref_result(s_op, s_a, s_b);
        end
        rem <= rem - 1;
      end else if (alu_start && !alu_done) begin
        s_op <= alu_op;
        s_a  <= alu_a;
        s_b  <= alu_b;
        if (alu_op == 3'd4) rem <= 2;
        else begin
          alu_done   <= 1'b1;
          alu_result <= ref_result(alu_op, alu_a, alu_b);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic do_txn(
    input int idx, input logic [2:0] op,
    input logic [7:0] a, input logic [7:0] b,
    output logic [N-1:0] g0, output int rc,
    output int sc, output int slast,
    output logic [15:0] res, output logic err,
    output logic [N-1:0] rv, output bit stable,
    output bit cleared);
    logic [7:0] ea, eb;
    logic [2:0] eo;
    bit is_alu;
    is_alu = (op >= 3'd1 && op <= 3'd4);
    ea = is_alu ? a : 8'h0;
    eb = is_alu ? b : 8'h0;
    eo = is_alu ? op : 3'h0;
    req_a[idx*8 +: 8] = a;
    req_b[idx*8 +: 8] = b;
    req_op[idx*3 +: 3] = op;
    req[idx] = 1'b1;
    #1;
    g0 = gnt;
    step();
    req[idx] = 1'b0;
    rc = -1; sc = 0; slast = -1;
    stable = 1'b1; cleared = 1'b0;
    res = 'x; err = 1'bx; rv = '0;
    for (int c = 1; c <= 20 && rc < 0; c++) begin
      #1;
      if (alu_start) begin
        sc++;
        slast = c;
      end
      if (rsp_valid != '0) begin
        rc = c;
        res = rsp_result;
        err = rsp_err;
        rv = rsp_valid;
        cleared = (alu_a == 0 && alu_b == 0 &&
                   alu_op == 0 && !alu_start);
      end else if (alu_a !== ea || alu_b !== eb ||
                   alu_op !== eo) begin
        stable = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req = '1;
    req_op = '0;
    step();
    step();
    checks++;
    if (gnt !== '0) begin
      errors++;
      $display("FAIL reset_gnt got=%b exp=0", gnt);
    end
    checks++;
    if (busy !== 1'b0 || rsp_valid !== '0) begin
      errors++;
      $display("FAIL reset_busy_rsp got=%b/%b exp=0/0",
               busy, rsp_valid);
    end
    checks++;
    if (alu_start !== 1'b0 || alu_a !== 0 || alu_b !== 0 ||
        alu_op !== 0 || rsp_result !== 0 || rsp_err !== 0) begin
      errors++;
      $display("FAIL reset_outs got=%b %h %h %h %h %b exp=0",
               alu_start, alu_a, alu_b, alu_op,
               rsp_result, rsp_err);
    end
    req = '0;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    logic [N-1:0] g0, rv;
    int rc, sc, sl;
    logic [15:0] res;
    logic err;
    bit st, cl;
    do_txn(0, 3'd1, 8'h0F, 8'h01, g0, rc, sc, sl,
           res, err, rv, st, cl);
    checks++;
    if (g0 !== 4'b0001) begin
      errors++;
      $display("FAIL add_gnt got=%b exp=0001", g0);
    end
    checks++;
    if (sc !== 1 || sl !== 1) begin
      errors++;
      $display("FAIL add_start got=%0d@%0d exp=1@1", sc, sl);
    end
    checks++;
    if (rc !== 3 || rv !== 4'b0001) begin
      errors++;
      $display("FAIL add_rsp got=%0d/%b exp=3/0001", rc, rv);
    end
    checks++;
    if (res !== 16'h0010 || err !== 1'b0) begin
      errors++;
      $display("FAIL add_result got=%h/%b exp=0010/0",
               res, err);
    end
  endtask

  task automatic test_mult();
    logic [N-1:0] g0, rv;
    int rc, sc, sl;
    logic [15:0] res;
    logic err;
    bit st, cl;
    do_txn(1, 3'd4, 8'hFF, 8'hFF, g0, rc, sc, sl,
           res, err, rv, st, cl);
    checks++;
    if (g0 !== 4'b0010) begin
      errors++;
      $display("FAIL mul_gnt got=%b exp=0010", g0);
    end
    checks++;
    if (sc !== 4 || sl !== 4) begin
      errors++;
      $display("FAIL mul_start got=%0d@%0d exp=4@4", sc, sl);
    end
    checks++;
    if (!st) begin
      errors++;
      $display("FAIL mul_stable got=0 exp=1");
    end
    checks++;
    if (rc !== 5 || rv !== 4'b0010 ||
        res !== 16'hFE01 || err !== 1'b0) begin
      errors++;
      $display("FAIL mul_rsp got=%0d/%b/%h/%b exp=5/0010/fe01/0",
               rc, rv, res, err);
    end
    checks++;
    if (!cl) begin
      errors++;
      $display("FAIL mul_drop got=start_or_operands exp=0");
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] eg, erv;
    logic [7:0] a [N];
    logic [7:0] b [N];
    int w;
    do_reset();
    for (int i = 0; i < N; i++) begin
      a[i] = 8'($urandom);
      b[i] = 8'($urandom);
      req_a[i*8 +: 8] = a[i];
      req_b[i*8 +: 8] = b[i];
      req_op[i*3 +: 3] = 3'd3;
    end
    req = '1;
    for (int c = 0; c < 20; c++) begin
      #1;
      w = (c / 4) % N;
      eg = (c % 4 == 0) ? N'(1) << w : '0;
      erv = (c % 4 == 3) ? N'(1) << w : '0;
      checks++;
      if (gnt !== eg) begin
        errors++;
        $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, gnt, eg);
      end
      checks++;
      if (rsp_valid !== erv) begin
        errors++;
        $display("FAIL rr_rsp c=%0d got=%b exp=%b",
                 c, rsp_valid, erv);
      end else if (erv != '0) begin
        checks++;
        if (rsp_result !== ref_result(3'd3, a[w], b[w])) begin
          errors++;
          $display("FAIL rr_result c=%0d got=%h exp=%h", c,
                   rsp_result, ref_result(3'd3, a[w], b[w]));
        end
      end
      step();
    end
    req = '0;
    step();
  endtask

  task automatic test_local_ops();
    logic [N-1:0] g0, rv;
    int rc, sc, sl;
    logic [15:0] res;
    logic err;
    bit st, cl;
    do_txn(2, 3'd0, 8'h12, 8'h34, g0, rc, sc, sl,
           res, err, rv, st, cl);
    checks++;
    if (g0 !== 4'b0100 || rc !== 1 || rv !== 4'b0100 ||
        res !== 0 || err !== 0 || sc !== 0) begin
      errors++;
      $display("FAIL nop got=%b/%0d/%b/%h/%b/%0d exp=0100/1/0100/0/0/0",
               g0, rc, rv, res, err, sc);
    end
    do_txn(3, 3'd6, 8'h56, 8'h78, g0, rc, sc, sl,
           res, err, rv, st, cl);
    checks++;
    if (g0 !== 4'b1000 || rc !== 1 || rv !== 4'b1000 ||
        res !== 0 || err !== 1 || sc !== 0) begin
      errors++;
      $display("FAIL rsvd got=%b/%0d/%b/%h/%b/%0d exp=1000/1/1000/0/1/0",
               g0, rc, rv, res, err, sc);
    end
  endtask

  task automatic test_timeout();
    logic [N-1:0] g0, rv;
    int rc, sc, sl;
    logic [15:0] res;
    logic err;
    bit st, cl;
    no_done = 1'b1;
    do_txn(2, 3'd4, 8'h33, 8'h44, g0, rc, sc, sl,
           res, err, rv, st, cl);
    no_done = 1'b0;
    checks++;
    if (rc !== TO + 1 || rv !== 4'b0100) begin
      errors++;
      $display("FAIL to_rsp got=%0d/%b exp=%0d/0100",
               rc, rv, TO + 1);
    end
    checks++;
    if (res !== 16'h0 || err !== 1'b1) begin
      errors++;
      $display("FAIL to_err got=%h/%b exp=0000/1", res, err);
    end
    checks++;
    if (sc !== TO || !cl || !st) begin
      errors++;
      $display("FAIL to_start got=%0d/%b/%b exp=%0d/1/1",
               sc, cl, st, TO);
    end
    do_txn(0, 3'd2, 8'hF0, 8'h3C, g0, rc, sc, sl,
           res, err, rv, st, cl);
    checks++;
    if (g0 !== 4'b0001 || rc !== 3 || res !== 16'h0030 ||
        err !== 1'b0) begin
      errors++;
      $display("FAIL to_next got=%b/%0d/%h/%b exp=0001/3/0030/0",
               g0, rc, res, err);
    end
  endtask

  task automatic test_reset_mid();
    req_a[15:8] = 8'h11;
    req_b[15:8] = 8'h22;
    req_op[5:3] = 3'd4;
    req[1] = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL mid_gnt got=%b exp=0010", gnt);
    end
    step();
    req[1] = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    checks++;
    if (alu_start !== 1'b0 || busy !== 1'b0 ||
        rsp_valid !== '0) begin
      errors++;
      $display("FAIL mid_reset got=%b/%b/%b exp=0/0/0",
               alu_start, busy, rsp_valid);
    end
    reset_n = 1'b1;
    step();
    req_a[7:0] = 8'h05;
    req_b[7:0] = 8'h06;
    req_op[2:0] = 3'd1;
    req_a[23:16] = 8'h07;
    req_b[23:16] = 8'h08;
    req_op[8:6] = 3'd1;
    req = 4'b0101;
    #1;
    checks++;
    if (gnt !== 4'b0001 || rsp_valid !== '0) begin
      errors++;
      $display("FAIL mid_first got=%b/%b exp=0001/0000",
               gnt, rsp_valid);
    end
    step();
    req = '0;
    step();
    step();
    #1;
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_result !== 16'h000B) begin
      errors++;
      $display("FAIL mid_rsp got=%b/%h exp=0001/000b",
               rsp_valid, rsp_result);
    end
    step();
  endtask

  typedef struct {
    int          t;
    int          idx;
    logic [15:0] r;
    logic        e;
  } rsp_t;

  task automatic test_random();
    rsp_t q[$];
    rsp_t x;
    logic [N-1:0] eg, erv;
    logic [2:0] op;
    int mp, free, last, pick;
    bit ebusy;
    do_reset();
    mp = N - 1;
    free = 0;
    last = -1;
    for (int t = 0; t < 600; t++) begin
      if (last >= 0) req[last] = 1'b0;
      last = -1;
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          req_a[i*8 +: 8] = 8'($urandom);
          req_b[i*8 +: 8] = 8'($urandom);
          req_op[i*3 +: 3] = 3'($urandom_range(0, 7));
          req[i] = 1'b1;
        end else if (req[i] && $urandom_range(0, 19) == 0) begin
          req[i] = 1'b0;
        end
      end
      #1;
      ebusy = (t < free);
      eg = '0;
      if (!ebusy && req != '0) begin
        pick = -1;
        for (int k = 1; k <= N && pick < 0; k++)
          if (req[(mp + k) % N]) pick = (mp + k) % N;
        mp = pick;
        last = pick;
        eg = N'(1) << pick;
        op = req_op[pick*3 +: 3];
        x.t = t + lat(op);
        x.idx = pick;
        x.r = ref_result(op, req_a[pick*8 +: 8],
                         req_b[pick*8 +: 8]);
        x.e = (op >= 3'd5);
        q.push_back(x);
        free = t + lat(op) + 1;
      end
      checks++;
      if (gnt !== eg || busy !== ebusy) begin
        errors++;
        $display("FAIL rnd_gnt t=%0d got=%b/%b exp=%b/%b",
                 t, gnt, busy, eg, ebusy);
      end
      erv = '0;
      if (q.size() > 0 && q[0].t == t) begin
        x = q.pop_front();
        erv = N'(1) << x.idx;
      end
      checks++;
      if (rsp_valid !== erv) begin
        errors++;
        $display("FAIL rnd_rsp t=%0d got=%b exp=%b",
                 t, rsp_valid, erv);
      end else if (erv != '0) begin
        checks++;
        if (rsp_result !== x.r || rsp_err !== x.e) begin
          errors++;
          $display("FAIL rnd_result t=%0d got=%h/%b exp=%h/%b",
                   t, rsp_result, rsp_err, x.r, x.e);
        end
      end
      step();
    end
    req = '0;
    repeat (8) step();
  endtask

  initial begin
    reset_n = 1'b0;
    req = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    test_reset();
    test_add();
    test_mult();
    test_round_robin();
    test_local_ops();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench time limit");
  end

endmodule
